// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor and its resolver: counter state
// encodings, default sizes, queue entry layout and the saturating increment.
package bp_pkg;

    localparam logic [1:0] STRONG_NT = 2'b00;
    localparam logic [1:0] WEAK_NT   = 2'b01;
    localparam logic [1:0] WEAK_T    = 2'b10;
    localparam logic [1:0] STRONG_T  = 2'b11;

    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 16;

    typedef struct packed {
        logic pred;
    } q_entry_t;

    // Counters narrower than 32 bits saturate at their own all-ones value.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_v;
        if (width >= 32'd32) begin
            max_v = 32'hFFFF_FFFF;
        end else begin
            max_v = (32'd1 << width) - 32'd1;
        end
        if (val >= max_v) begin
            sat_inc = max_v;
        end else begin
            sat_inc = val + 32'd1;
        end
    endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Issue/predict/resolve bundle between the pipeline, the predictor and the resolver.
interface branch_resolver_if
    import bp_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             issue;
    logic             issue_ready;
    logic             request;
    logic             pred_in;
    logic             resolve_valid;
    logic             resolve_taken;
    logic             result;
    logic             taken;
    logic             mispredict;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] miss_count;

    modport master (
        output issue, pred_in, resolve_valid, resolve_taken,
        input  issue_ready, request, result, taken, mispredict, full, empty,
               branch_count, miss_count
    );

    modport slave (
        input  issue, pred_in, resolve_valid, resolve_taken,
        output issue_ready, request, result, taken, mispredict, full, empty,
               branch_count, miss_count
    );
endinterface

// File: rtl/branch_resolver_pred_queue.sv
// In-order circular queue of outstanding predictions. Allocation and capture are
// separate because the prediction arrives one cycle after the slot is allocated.
module pred_queue
    import bp_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int OW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic          cap_en_i,
    input  logic [AW-1:0] cap_idx_i,
    input  logic          cap_pred_i,
    output logic [AW-1:0] wr_ptr_o,
    output logic [AW-1:0] rd_ptr_o,
    output logic          head_pred_o,
    output logic          full_o,
    output logic          empty_o
);
    q_entry_t      mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [OW-1:0] occ_q, occ_d;
    logic          full_q, full_d, empty_q, empty_d;

    // Pointer and occupancy next state; a flush drops everything including the head.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        occ_d = occ_q;
        if (flush_i) begin
            rd_d  = rd_q + AW'(1'b1);
            wr_d  = rd_q + AW'(1'b1);
            occ_d = '0;
        end else begin
            wr_d  = push_i ? wr_q + AW'(1'b1) : wr_q;
            rd_d  = pop_i ? rd_q + AW'(1'b1) : rd_q;
            occ_d = occ_q + OW'(push_i) - OW'(pop_i);
        end
        full_d  = (occ_d == OW'(DEPTH));
        empty_d = (occ_d == '0);
    end

    // Pointer, occupancy and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            occ_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            occ_q   <= occ_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Late prediction capture; storage contents need no reset.
    always_ff @(posedge clk) begin
        if (cap_en_i) begin
            mem_q[cap_idx_i].pred <= cap_pred_i;
        end
    end

    assign wr_ptr_o    = wr_q;
    assign rd_ptr_o    = rd_q;
    assign head_pred_o = mem_q[rd_q].pred;
    assign full_o      = full_q;
    assign empty_o     = empty_q;
endmodule

// File: rtl/branch_resolver.sv
// Resolves outstanding branches against their predictions, drives predictor
// training, flags mispredictions with a flush and keeps saturating statistics.
module branch_resolver
    import bp_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    parameter  int CNT_W = DEF_CNT_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    branch_resolver_if.slave    bus
);
    logic             full_s, empty_s, q_head_s;
    logic             accept_s, resolve_s, head_pred_s, miss_s;
    logic [AW-1:0]    wr_ptr_s, rd_ptr_s;
    logic             pending_q, pending_d;
    logic [AW-1:0]    pend_idx_q, pend_idx_d;
    logic             result_q, result_d, taken_q, taken_d, mis_q, mis_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d, miss_cnt_q, miss_cnt_d;

    assign accept_s    = bus.issue & ~full_s;
    assign resolve_s   = bus.resolve_valid & ~empty_s;
    // Resolving right after issue: the prediction is still on pred_in, not in the queue.
    assign head_pred_s = (pending_q && (pend_idx_q == rd_ptr_s)) ? bus.pred_in : q_head_s;
    assign miss_s      = resolve_s & (head_pred_s ^ bus.resolve_taken);

    pred_queue #(.DEPTH(DEPTH)) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (accept_s),
        .pop_i       (resolve_s),
        .flush_i     (miss_s),
        .cap_en_i    (pending_q),
        .cap_idx_i   (pend_idx_q),
        .cap_pred_i  (bus.pred_in),
        .wr_ptr_o    (wr_ptr_s),
        .rd_ptr_o    (rd_ptr_s),
        .head_pred_o (q_head_s),
        .full_o      (full_s),
        .empty_o     (empty_s)
    );

    // Pending capture tracking, training strobes and statistics next state.
    always_comb begin
        pending_d  = 1'b0;
        pend_idx_d = pend_idx_q;
        if (accept_s && !miss_s) begin
            pending_d  = 1'b1;
            pend_idx_d = wr_ptr_s;
        end else begin
            pending_d  = 1'b0;
            pend_idx_d = pend_idx_q;
        end
        result_d     = resolve_s;
        taken_d      = resolve_s & bus.resolve_taken;
        mis_d        = miss_s;
        branch_cnt_d = resolve_s ? CNT_W'(sat_inc(32'(branch_cnt_q), CNT_W)) : branch_cnt_q;
        miss_cnt_d   = miss_s ? CNT_W'(sat_inc(32'(miss_cnt_q), CNT_W)) : miss_cnt_q;
    end

    // Resolver state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q    <= 1'b0;
            pend_idx_q   <= '0;
            result_q     <= 1'b0;
            taken_q      <= 1'b0;
            mis_q        <= 1'b0;
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            pending_q    <= pending_d;
            pend_idx_q   <= pend_idx_d;
            result_q     <= result_d;
            taken_q      <= taken_d;
            mis_q        <= mis_d;
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign bus.issue_ready  = ~full_s;
    assign bus.request      = accept_s;
    assign bus.result       = result_q;
    assign bus.taken        = taken_q;
    assign bus.mispredict   = mis_q;
    assign bus.full         = full_s;
    assign bus.empty        = empty_s;
    assign bus.branch_count = branch_cnt_q;
    assign bus.miss_count   = miss_cnt_q;
endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench: one cycle per table record, applied to a 16-bit and a 2-bit
// counter instance in parallel, followed by a mid-cycle reset sequence.
module tb_branch_resolver;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    branch_resolver_if #(.CNT_W(16)) bus16 ();
    branch_resolver_if #(.CNT_W(2))  bus2 ();

    assign bus2.issue         = bus16.issue;
    assign bus2.pred_in       = bus16.pred_in;
    assign bus2.resolve_valid = bus16.resolve_valid;
    assign bus2.resolve_taken = bus16.resolve_taken;

    branch_resolver #(.DEPTH(4), .CNT_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    branch_resolver #(.DEPTH(4), .CNT_W(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic iss, pin, rv, rt;
        logic e_rdy, e_req;
        logic e_res, e_tkn, e_mis, e_full, e_empty;
        int   e_bc, e_mc;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] in_b, input logic [1:0] cmb,
                                input logic [4:0] rg, input int bc, input int mc);
        vec_t v;
        {v.iss, v.pin, v.rv, v.rt} = in_b;
        {v.e_rdy, v.e_req} = cmb;
        {v.e_res, v.e_tkn, v.e_mis, v.e_full, v.e_empty} = rg;
        v.e_bc = bc;
        v.e_mc = mc;
        return v;
    endfunction

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bus16.issue         = v.iss;
        bus16.pred_in       = v.pin;
        bus16.resolve_valid = v.rv;
        bus16.resolve_taken = v.rt;
        #1;
        chk("issue_ready", idx, 32'(bus16.issue_ready), 32'(v.e_rdy));
        chk("request",     idx, 32'(bus16.request),     32'(v.e_req));
        chk("request_w2",  idx, 32'(bus2.request),      32'(v.e_req));
        @(posedge clk);
        #1;
        chk("result",     idx, 32'(bus16.result),     32'(v.e_res));
        chk("taken",      idx, 32'(bus16.taken),      32'(v.e_tkn));
        chk("mispredict", idx, 32'(bus16.mispredict), 32'(v.e_mis));
        chk("full",       idx, 32'(bus16.full),       32'(v.e_full));
        chk("empty",      idx, 32'(bus16.empty),      32'(v.e_empty));
        chk("branch_cnt", idx, 32'(bus16.branch_count), 32'(v.e_bc));
        chk("miss_cnt",   idx, 32'(bus16.miss_count),   32'(v.e_mc));
        chk("result_w2",  idx, 32'(bus2.result),      32'(v.e_res));
        chk("mispred_w2", idx, 32'(bus2.mispredict),  32'(v.e_mis));
        chk("empty_w2",   idx, 32'(bus2.empty),       32'(v.e_empty));
        chk("branch_w2",  idx, 32'(bus2.branch_count), 32'(sat3(v.e_bc)));
        chk("miss_w2",    idx, 32'(bus2.miss_count),   32'(sat3(v.e_mc)));
    endtask

    task automatic chk_reset_state(input int idx);
        chk("rst_result", idx, 32'(bus16.result),       32'd0);
        chk("rst_taken",  idx, 32'(bus16.taken),        32'd0);
        chk("rst_mis",    idx, 32'(bus16.mispredict),   32'd0);
        chk("rst_full",   idx, 32'(bus16.full),         32'd0);
        chk("rst_empty",  idx, 32'(bus16.empty),        32'd1);
        chk("rst_bc",     idx, 32'(bus16.branch_count), 32'd0);
        chk("rst_mc",     idx, 32'(bus16.miss_count),   32'd0);
        chk("rst_bc_w2",  idx, 32'(bus2.branch_count),  32'd0);
        chk("rst_mc_w2",  idx, 32'(bus2.miss_count),    32'd0);
        chk("rst_res_w2", idx, 32'(bus2.result),        32'd0);
    endtask

    vec_t vecs[$];
    vec_t pre_rst[$];
    vec_t post_rst[$];

    initial begin
        // {iss,pin,rv,rt}, {rdy,req}, {result,taken,mispredict,full,empty}, branches, misses
        vecs.push_back(mk(4'b1000, 2'b11, 5'b00000, 0, 0));   // single issue
        vecs.push_back(mk(4'b0100, 2'b10, 5'b00000, 0, 0));   // prediction 1 arrives
        vecs.push_back(mk(4'b0011, 2'b10, 5'b11001, 1, 0));   // correct resolve
        vecs.push_back(mk(4'b0000, 2'b10, 5'b00001, 1, 0));
        vecs.push_back(mk(4'b1000, 2'b11, 5'b00000, 1, 0));   // issue, then bypass resolve
        vecs.push_back(mk(4'b0011, 2'b10, 5'b11101, 2, 1));   // pred 0 vs taken: mispredict
        vecs.push_back(mk(4'b0000, 2'b10, 5'b00001, 2, 1));
        vecs.push_back(mk(4'b1000, 2'b11, 5'b00000, 2, 1));   // fill: preds 1,1,0,1
        vecs.push_back(mk(4'b1100, 2'b11, 5'b00000, 2, 1));
        vecs.push_back(mk(4'b1100, 2'b11, 5'b00000, 2, 1));
        vecs.push_back(mk(4'b1000, 2'b11, 5'b00010, 2, 1));
        vecs.push_back(mk(4'b1100, 2'b00, 5'b00010, 2, 1));   // 5th issue blocked
        vecs.push_back(mk(4'b1011, 2'b00, 5'b11000, 3, 1));   // resolve while full: still blocked
        vecs.push_back(mk(4'b0011, 2'b10, 5'b11000, 4, 1));
        vecs.push_back(mk(4'b0010, 2'b10, 5'b10000, 5, 1));
        vecs.push_back(mk(4'b0011, 2'b10, 5'b11001, 6, 1));
        vecs.push_back(mk(4'b0000, 2'b10, 5'b00001, 6, 1));
        vecs.push_back(mk(4'b1000, 2'b11, 5'b00000, 6, 1));   // three outstanding: 1,0,1
        vecs.push_back(mk(4'b1100, 2'b11, 5'b00000, 6, 1));
        vecs.push_back(mk(4'b1000, 2'b11, 5'b00000, 6, 1));
        vecs.push_back(mk(4'b1110, 2'b11, 5'b10101, 7, 2));   // miss + squashed issue
        vecs.push_back(mk(4'b0111, 2'b10, 5'b00001, 7, 2));   // squashed branch unresolvable
        vecs.push_back(mk(4'b1000, 2'b11, 5'b00000, 7, 2));   // fresh issue
        vecs.push_back(mk(4'b0000, 2'b10, 5'b00000, 7, 2));
        vecs.push_back(mk(4'b0010, 2'b10, 5'b10001, 8, 2));
        vecs.push_back(mk(4'b1000, 2'b11, 5'b00000, 8, 2));   // five bypass mispredicts
        vecs.push_back(mk(4'b0011, 2'b10, 5'b11101, 9, 3));
        vecs.push_back(mk(4'b1000, 2'b11, 5'b00000, 9, 3));
        vecs.push_back(mk(4'b0110, 2'b10, 5'b10101, 10, 4));
        vecs.push_back(mk(4'b1000, 2'b11, 5'b00000, 10, 4));
        vecs.push_back(mk(4'b0011, 2'b10, 5'b11101, 11, 5));
        vecs.push_back(mk(4'b1000, 2'b11, 5'b00000, 11, 5));
        vecs.push_back(mk(4'b0110, 2'b10, 5'b10101, 12, 6));
        vecs.push_back(mk(4'b1000, 2'b11, 5'b00000, 12, 6));
        vecs.push_back(mk(4'b0011, 2'b10, 5'b11101, 13, 7));
        vecs.push_back(mk(4'b0011, 2'b10, 5'b00001, 13, 7));  // resolve while empty ignored
        vecs.push_back(mk(4'b1000, 2'b11, 5'b00000, 13, 7));  // issue + resolve together
        vecs.push_back(mk(4'b1100, 2'b11, 5'b00000, 13, 7));
        vecs.push_back(mk(4'b1011, 2'b11, 5'b11000, 14, 7));
        vecs.push_back(mk(4'b0110, 2'b10, 5'b10000, 15, 7));
        vecs.push_back(mk(4'b0011, 2'b10, 5'b11001, 16, 7));
        vecs.push_back(mk(4'b1000, 2'b11, 5'b00000, 16, 7));  // correct bypass resolve
        vecs.push_back(mk(4'b0111, 2'b10, 5'b11001, 17, 7));
        vecs.push_back(mk(4'b0000, 2'b10, 5'b00001, 17, 7));

        pre_rst.push_back(mk(4'b1000, 2'b11, 5'b00000, 17, 7));
        pre_rst.push_back(mk(4'b1100, 2'b11, 5'b00000, 17, 7));
        pre_rst.push_back(mk(4'b1011, 2'b11, 5'b11000, 18, 7)); // two left outstanding

        post_rst.push_back(mk(4'b1000, 2'b11, 5'b00000, 0, 0));
        post_rst.push_back(mk(4'b0100, 2'b10, 5'b00000, 0, 0));
        post_rst.push_back(mk(4'b0011, 2'b10, 5'b11001, 1, 0));

        rst_n               = 1'b0;
        bus16.issue         = 1'b0;
        bus16.pred_in       = 1'b0;
        bus16.resolve_valid = 1'b0;
        bus16.resolve_taken = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_state(0);
        chk("rst_ready", 0, 32'(bus16.issue_ready), 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i + 1);
        end
        for (int i = 0; i < pre_rst.size(); i++) begin
            run_vec(pre_rst[i], 100 + i);
        end

        bus16.issue         = 1'b0;
        bus16.pred_in       = 1'b0;
        bus16.resolve_valid = 1'b0;
        bus16.resolve_taken = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_reset_state(200);
        @(posedge clk);
        #1;
        chk_reset_state(201);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_state(202);

        for (int i = 0; i < post_rst.size(); i++) begin
            run_vec(post_rst[i], 300 + i);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/branch_resolver.md
# branch_resolver

Issuing and resolving end of the saturating-counter branch predictor. Each issued branch raises a one-cycle prediction request. The resolver captures the returned prediction into an in-order queue of outstanding branches. When the execution unit reports the actual outcome, the resolver compares it with the oldest prediction, drives the training update (result/taken) back to the predictor, flags mispredictions, flushes younger entries, and keeps saturating statistics.

## Interface
- DEPTH, 4: outstanding-branch queue entries (power of two, ≥2)
- CNT_W, 16: width of statistics counters

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- issue  in  1  new branch wants a prediction
- issue_ready  out  1  combinational, = ~full
- request  out  1  combinational, = issue & issue_ready; goes to predictor request
- pred_in  in  1  predictor output, valid in the cycle after request
- resolve_valid  in  1  oldest outstanding branch resolved this cycle
- resolve_taken  in  1  actual outcome of that branch
- result  out  1  registered update strobe to predictor
- taken  out  1  registered actual outcome accompanying result
- mispredict  out  1  registered one-cycle pulse, prediction ≠ outcome
- full  out  1  registered, DEPTH entries valid
- empty  out  1  registered, zero entries valid
- branch_count  out  CNT_W  resolved branches, saturating at all-ones
- miss_count  out  CNT_W  mispredicted branches, saturating at all-ones

## Operation
- Queue: circular, DEPTH entries of {pred}. Write pointer and read pointer are log2(DEPTH) bits wide and wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
- Issue accepted (request=1) at edge t:
  - allocate the entry at the write pointer, write pointer +1, occupancy +1
  - set `pending`=1 with `pend_idx` = allocated slot
- Edge t+1: pred_in is written into queue[pend_idx] and `pending` clears, unless a new request sets it again.
- Resolve (resolve_valid=1 and not empty):
  - head prediction = pred_in if pending and pend_idx == read pointer (bypass); otherwise queue[read pointer]
  - result←1, taken←resolve_taken
  - branch_count +1 (saturating)
  - on mismatch: mispredict←1, miss_count +1 (saturating), flush
- Flush:
  - write pointer ← read pointer + 1 (the head is popped), occupancy ← 0, pending ← 0
  - a same-cycle accepted issue is squashed: it never occupies the queue, but its request pulse has already reached the predictor and its prediction is discarded
- Correct resolve: read pointer +1, occupancy −1.
- resolve_valid while empty is ignored: no update, no count change.
- Simultaneous accepted issue and correct resolve: occupancy unchanged, both pointers advance.
- Issue while full: issue_ready=0, so no request is made. A resolve in the same cycle does not make room until the next cycle.
- Saturation: a counter at all-ones stays at all-ones; no wrap-around.

## Timing
- Reset values: result=0, taken=0, mispredict=0, full=0, empty=1, branch_count=0, miss_count=0, pointers=0, pending=0. Queue contents are don't-care.
- request is combinational, same cycle as issue.
- Prediction capture completes 1 cycle after request.
- result, taken and mispredict are asserted for exactly 1 cycle, in the cycle after the resolving edge. The predictor trains on the following edge.
- Counters, full and empty update on the resolving or issuing edge.
- Minimum issue-to-resolve spacing: resolve may occur in the cycle after issue, using the bypass path.
- Reset asserted mid-operation clears everything immediately. Outstanding branches are lost and no result pulse is emitted.

## Structure
- Shared package `bp_pkg`:
  - predictor counter state constants (STRONG_NT=2'b00, WEAK_NT=2'b01, WEAK_T=2'b10, STRONG_T=2'b11)
  - DEPTH and CNT_W defaults
  - a `sat_inc` function used by both counters
- Sub-module `pred_queue`: the circular buffer with pointers, occupancy, full/empty, and a flush input. The top level holds the pending/bypass logic, the update/mispredict registers and the counters.

## Test plan
- Reset, then issue once with pred_in=1 the next cycle; resolve_taken=1 two cycles later → result=1, taken=1, mispredict=0, branch_count=1, miss_count=0, empty=1.
- Issue at cycle 0 and resolve at cycle 1 with pred_in=0 and resolve_taken=1 (bypass) → mispredict=1 at cycle 2, miss_count=1, queue empty.
- Issue 4 branches with predictions 1,1,0,1 (DEPTH=4) → full=1, issue_ready=0 and request=0 on a 5th issue. Resolve outcomes 1,1,0,1 → 4 result pulses, no mispredict, empty=1.
- Three branches outstanding; oldest resolves with a mismatch while issue=1 in the same cycle → mispredict pulse, occupancy 0, squashed issue never resolvable; the next issue lands in a fresh slot and resolves correctly.
- CNT_W=2: run 5 mispredicted resolutions → miss_count=3 and branch_count=3, both held at 3; resolve_valid while empty → no result pulse and counts unchanged.
- Assert rst_n=0 asynchronously mid-cycle with 2 branches outstanding → outputs return to reset values before the next edge; empty=1 after release.
